itf_port_ctrl: RTL
==================

# itf_port_ctrl

Chip-side controller for the shared off-chip data port, sitting between the on-chip request arbiter and the bidirectional DRAM port. It serialises one transfer at a time:
- accepts a request (direction, DRAM word address, beat count);
- issues a single command beat;
- then either streams write data out or buffers read data in, owning the bus-direction (output-enable) control.

Bidirectional pads are split into separate in/out/oe nets here; the pad ring merges them.

## Interface
- PORT_WIDTH, 128, port data width (command and data beats)
- DRAM_ADDR_WIDTH, 32, DRAM word-address width
- ADDR_WIDTH, 16, beat-count width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- req_vld / req_rdy  in / out  1  request handshake
- req_dir  in  1  transfer direction: 1 = write to DRAM, 0 = read from DRAM
- req_addr  in  DRAM_ADDR_WIDTH  start word address
- req_num  in  ADDR_WIDTH  beat count
- wr_dat / wr_vld / wr_rdy  in / in / out  PORT_WIDTH/1/1  write stream from core
- rd_dat / rd_vld / rd_last / rd_rdy  out / out / out / in  PORT_WIDTH/1/1/1  read stream to core
- o_oe  out  1  1 = chip drives dat/vld/last and DRAM drives rdy; 0 = reverse
- o_dat / o_vld / o_last  out  PORT_WIDTH/1/1  chip-driven port side
- i_rdy  in  1  DRAM ready (valid when o_oe=1)
- i_dat / i_vld / i_last  in  PORT_WIDTH/1/1  DRAM-driven port side (valid when o_oe=0)
- o_rdy  out  1  chip ready to DRAM (meaningful when o_oe=0)
- done  out  1  one-cycle pulse at transfer completion
- err  out  1  sticky read-length mismatch

## Operation
- **IDLE**
  - req_rdy=1.
  - On req_vld: latch dir/addr/num, clear err and the beat counter, go CMD.
  - If num==0: no command is issued; go FNH.
- **CMD**
  - o_vld=1.
  - o_dat = {zeros, num[15:0] at bits 48:33, addr at bits 32:1, dir at bit 0}.
  - o_last=0.
  - On i_rdy: go WR if dir=1, else RD.
- **WR**
  - o_dat=wr_dat, o_vld=wr_vld, wr_rdy=i_rdy, o_last=(cnt==num-1).
  - Each o_vld&i_rdy increments cnt.
  - The beat with o_last accepted: go FNH.
- **RD**
  - o_oe=0, o_rdy = read buffer not full.
  - Each i_vld&o_rdy pushes i_dat plus a last flag into the 2-entry buffer and increments cnt.
  - Last flag = (cnt==num-1); this beat ends RD and goes FNH.
  - i_last mismatched against (cnt==num-1) on any accepted beat sets err.
- **FNH**
  - Waits until the read buffer is empty, pulses done, returns to IDLE.
- o_oe=1 in every state except RD.
- o_vld=0 and o_last=0 outside CMD/WR.
- o_rdy=0 whenever o_oe=1.
- The read buffer drains to rd_* independently of state: rd_vld = not empty, rd_last = head's last flag.
- Beat-count arithmetic is ADDR_WIDTH bits, compared without overflow; num=65535 is legal.
- req_rdy=0 outside IDLE; no new request overlaps an active transfer.

## Timing
- Reset values: state IDLE, o_oe=1, o_vld=0, o_last=0, o_rdy=0, req_rdy=1, rd_vld=0, done=0, err=0, buffer empty, cnt=0.
- State, o_oe and the buffer are registered.
- Port-side vld/rdy/dat are combinational from state, buffer and stream inputs only; there is no path i_rdy→o_vld.
- Request accept to command on the port: 1 cycle.
- Command handshake to o_oe=0: next cycle. The DRAM may drive i_vld in that same cycle.
- Read: port beat to rd_vld = 1 cycle. The buffer sustains 1 beat/cycle with rd_rdy held high.
- After the last read beat, o_oe returns to 1 in the next cycle.
- done is asserted the cycle the buffer goes empty in FNH.
- DRAM ready may drop for any number of cycles in CMD/WR; the controller holds o_dat/o_vld stable only while wr_vld holds.
- Simultaneous buffer push and pop when full: not possible, since o_rdy=0 when full. When 1 entry is occupied, push and pop in the same cycle keep the count at 1.
- rst mid-transfer: every output returns to its reset value next cycle and buffer contents are discarded.

## Structure
- Shared package itf_pkg:
  - state enum (IDLE/CMD/RD/WR/FNH);
  - command-field bit offsets: DIR_BIT=0, ADDR_LSB=1, NUM_LSB=1+DRAM_ADDR_WIDTH.
- One sub-module, itf_skid_fifo: 2-entry, PORT_WIDTH+1 bits wide, with full/empty flags; used for the read path.

## Test plan
- **Write, 4 beats:** req dir=1 addr=0x100 num=4 with wr_vld always high.
  - Expect the command beat with o_dat[48:0] = {16'd4, 32'h100, 1'b1}.
  - Then 4 data beats, o_last on the 4th, done 1 cycle later, o_oe=1 throughout.
- **Read, 8 beats:** dir=0 addr=0x200 num=8, DRAM supplies i_last on beat 8.
  - Expect o_oe=0 the cycle after the command.
  - rd_dat in order, rd_last on the 8th, done after drain, err=0.
- **Read backpressure:** rd_rdy low for 5 cycles mid-burst.
  - Expect o_rdy to fall after 2 buffered beats.
  - No beat lost or duplicated; sequence resumes intact.
- **Length mismatch:** num=4, DRAM asserts i_last on beat 3.
  - Expect err=1, held until the next request is accepted.
- **num=0:**
  - Expect no o_vld at all, done 2 cycles after accept, req_rdy back to 1.
- **Reset mid-write:** rst asserted after beat 2 of 6.
  - Next cycle: o_vld=0, o_oe=1, req_rdy=1.
  - A fresh 1-beat write then completes normally.

Source files
------------

// File: rtl/itf_pkg.sv
// Shared types and command-beat field layout for the off-chip port controller.
package itf_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StRd,
    StWr,
    StFnh
  } state_e;

  // Command-beat field offsets; the beat count sits directly above the address.
  localparam int unsigned DIR_BIT  = 0;
  localparam int unsigned ADDR_LSB = 1;

  function automatic int unsigned num_lsb(input int unsigned dram_addr_width);
    return ADDR_LSB + dram_addr_width;
  endfunction

  localparam int unsigned NUM_LSB = num_lsb(32);

endpackage

// File: rtl/itf_skid_fifo.sv
// Two-entry FIFO buffering read beats ({last, data}) between the DRAM port and the core.
module itf_skid_fifo #(
  parameter int unsigned WIDTH = 129
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wptr;
  logic             r_rptr;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rptr];

  // Pointer and occupancy bookkeeping; reset discards any buffered beats.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/itf_port_ctrl.sv
// Serialises one DRAM transfer at a time over the shared bidirectional port:
// command beat, then either a write stream out or a buffered read stream in.
module itf_port_ctrl
  import itf_pkg::*;
#(
  parameter int unsigned PORT_WIDTH      = 128,
  parameter int unsigned DRAM_ADDR_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH      = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_vld,
  output logic                       req_rdy,
  input  logic                       req_dir,
  input  logic [DRAM_ADDR_WIDTH-1:0] req_addr,
  input  logic [ADDR_WIDTH-1:0]      req_num,
  input  logic [PORT_WIDTH-1:0]      wr_dat,
  input  logic                       wr_vld,
  output logic                       wr_rdy,
  output logic [PORT_WIDTH-1:0]      rd_dat,
  output logic                       rd_vld,
  output logic                       rd_last,
  input  logic                       rd_rdy,
  output logic                       o_oe,
  output logic [PORT_WIDTH-1:0]      o_dat,
  output logic                       o_vld,
  output logic                       o_last,
  input  logic                       i_rdy,
  input  logic [PORT_WIDTH-1:0]      i_dat,
  input  logic                       i_vld,
  input  logic                       i_last,
  output logic                       o_rdy,
  output logic                       done,
  output logic                       err
);

  localparam int unsigned NumLsb = num_lsb(DRAM_ADDR_WIDTH);

  state_e                     r_state;
  state_e                     w_state_d;
  logic                       r_oe;
  logic                       r_dir;
  logic [DRAM_ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0]      r_num;
  logic [ADDR_WIDTH-1:0]      r_cnt;
  logic                       r_err;
  logic                       w_last_beat;
  logic                       w_num_zero;
  logic                       w_wr_hs;
  logic                       w_rd_push;
  logic [PORT_WIDTH-1:0]      w_cmd;
  logic                       w_fifo_full;
  logic                       w_fifo_empty;
  logic [PORT_WIDTH:0]        w_fifo_head;

  // Only evaluated when num >= 1, so num-1 never wraps.
  assign w_last_beat = (r_cnt == r_num - ADDR_WIDTH'(1));
  assign w_num_zero  = (r_num == '0);
  assign w_wr_hs     = (r_state == StWr) & wr_vld & i_rdy;
  assign w_rd_push   = (r_state == StRd) & i_vld & ~w_fifo_full;

  assign o_oe    = r_oe;
  assign err     = r_err;
  assign rd_vld  = ~w_fifo_empty;
  assign rd_dat  = w_fifo_head[PORT_WIDTH-1:0];
  assign rd_last = w_fifo_head[PORT_WIDTH];

  // Command beat layout: {zeros, num, addr, dir}.
  always_comb begin
    w_cmd = '0;
    w_cmd[DIR_BIT] = r_dir;
    w_cmd[ADDR_LSB +: DRAM_ADDR_WIDTH] = r_addr;
    w_cmd[NumLsb +: ADDR_WIDTH] = r_num;
  end

  // State register; bus direction is registered from the next state so it flips with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_oe    <= 1'b1;
    end else begin
      r_state <= w_state_d;
      r_oe    <= (w_state_d != StRd);
    end
  end

  // Next-state logic; a zero-length request passes through Cmd without issuing a command.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (req_vld) w_state_d = StCmd;
      StCmd: begin
        if (w_num_zero)  w_state_d = StFnh;
        else if (i_rdy)  w_state_d = r_dir ? StWr : StRd;
      end
      StWr:   if (w_wr_hs && w_last_beat) w_state_d = StFnh;
      StRd:   if (w_rd_push && w_last_beat) w_state_d = StFnh;
      StFnh:  if (w_fifo_empty) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Request capture, beat counting and sticky read-length error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dir  <= 1'b0;
      r_addr <= '0;
      r_num  <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else if (r_state == StIdle && req_vld) begin
      r_dir  <= req_dir;
      r_addr <= req_addr;
      r_num  <= req_num;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_wr_hs || w_rd_push) r_cnt <= r_cnt + ADDR_WIDTH'(1);
      if (w_rd_push && (i_last != w_last_beat)) r_err <= 1'b1;
    end
  end

  // Port-side outputs, decoded from state; o_vld never depends on i_rdy.
  always_comb begin
    req_rdy = 1'b0;
    wr_rdy  = 1'b0;
    o_dat   = '0;
    o_vld   = 1'b0;
    o_last  = 1'b0;
    o_rdy   = 1'b0;
    done    = 1'b0;
    unique case (r_state)
      StIdle: req_rdy = 1'b1;
      StCmd: begin
        o_vld = ~w_num_zero;
        o_dat = w_cmd;
      end
      StWr: begin
        o_dat  = wr_dat;
        o_vld  = wr_vld;
        wr_rdy = i_rdy;
        o_last = w_last_beat;
      end
      StRd:  o_rdy = ~w_fifo_full;
      StFnh: done  = w_fifo_empty;
      default: ;
    endcase
  end

  itf_skid_fifo #(
    .WIDTH(PORT_WIDTH + 1)
  ) u_rd_fifo (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_push (w_rd_push),
    .i_data ({w_last_beat, i_dat}),
    .i_pop  (rd_rdy),
    .o_data (w_fifo_head),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

endmodule
